grid_port_arbiter: RTL and testbench
====================================

# grid_port_arbiter

Shares the single read/write port A of the Tetris grid memory between two requesters: requester 0 is the game-logic grid controller, requester 1 is a secondary grid client such as a line-clear/collapse engine or debug loader. It grants at most one access per cycle using round-robin priority. A bounded lock lets a requester perform an uninterrupted read-modify-write sequence. It also tracks in-flight reads so that each returned word is steered to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 8, grid address width
- DATA_W, 8, grid word width
- READ_LATENCY, 1, cycles from accepted read to valid mem_q (1..4)
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held (2..255)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this access
- addr0 / addr1  in  ADDR_W  grid address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for that requester
- rdata  out  DATA_W  read data; equals mem_q
- mem_addr  out  ADDR_W  grid memory port A address
- mem_data  out  DATA_W  grid memory port A write data
- mem_we  out  1  grid memory port A write enable
- mem_q  in  DATA_W  grid memory port A read data

## Operation
State:
- last: the last-granted requester. Reset value 1, so requester 0 wins the first tie.
- lock_act, lock_own: lock active flag and lock owner.
- lock_cnt: 8-bit count of locked cycles.
- rd_pipe: READ_LATENCY-deep shift register of {valid, id}.

Arbitration (combinational, evaluated every cycle):
- reset = 1: gnt0 = gnt1 = 0 and mem_we = 0.
- lock_act = 1: only lock_own may be granted. The other requester stalls, with its gnt held at 0.
- Unlocked, single requester: that requester is granted.
- Unlocked, both requesting: grant goes to the requester that is not `last`.
- No requester: mem_we = 0. mem_addr and mem_data keep their last granted values.
- mem_addr, mem_data and mem_we are muxed from the granted requester. mem_we = granted we.

Registered updates on each grant:
- last ← granted id.
- Lock is set when the granted access has lock = 1. This sets lock_act = 1 and lock_own = id. lock_cnt increments, and is set to 1 on the first locked cycle.
- Lock is cleared when any of the following holds:
  - the owner is granted with lock = 0;
  - the owner has req = 0 while lock_act = 1;
  - lock_cnt reaches LOCK_MAX. In that case the next cycle is arbitrated unlocked and `last` = owner, so the other requester wins any tie. This guarantees forward progress.
- Read tracking: a granted read pushes {1, id} into rd_pipe. Any other cycle pushes {0, x}.
- Read response: the rd_pipe output drives rvalid0/rvalid1 for exactly one cycle, with rdata = mem_q in that cycle.
- Writes produce no response.

## Timing
- Grant, memory address, data and write enable all appear in the same cycle as the request. A request that is not granted must be held by the requester until it is granted.
- Write: the memory captures it at the clock edge ending the grant cycle.
- Read accepted at cycle t: rvalid pulses at cycle t+READ_LATENCY.
- Back-to-back reads: one accepted per cycle, with responses returned in order.
- Simultaneous lock expiry and a new request from the owner: the owner is still granted that cycle if it is sole requester. Otherwise the other requester wins.
- Reset mid-operation takes effect at the next edge:
  - rd_pipe is cleared, so in-flight reads are dropped and no rvalid appears afterward.
  - lock_act = 0, lock_cnt = 0, last = 1.
- Reset values of the outputs:
  - gnt0, gnt1, rvalid0, rvalid1, mem_we = 0.
  - mem_addr, mem_data = 0 via a registered hold.
  - rdata follows mem_q.

## Test plan
- Sole read by req0 to addr 0x2A, with memory holding 0x5C: gnt0 = 1 in cycle t, mem_we = 0, rvalid0 = 1 with rdata = 0x5C at t+1, and rvalid1 stays 0.
- Both requesting continuously for 6 cycles after reset: grants alternate 0,1,0,1,0,1 with no idle cycle.
- req1 issues a locked read of 0x10 and then an unlocked write of 0x10 ← 0x33, while req0 requests throughout: gnt1 is granted for 2 cycles, gnt0 = 0 during them, gnt0 = 1 on the 3rd cycle, and a later read of 0x10 returns 0x33.
- req0 holds lock = 1 continuously with LOCK_MAX = 4 while req1 requests: req0 is granted 4 cycles, then req1 is granted on cycle 5.
- req0 read is accepted with READ_LATENCY = 3 and reset is asserted 1 cycle later: no rvalid0 for 5 cycles, and after release req0 wins the first tie.
- Write with both we0 and we1 set: only the granted requester's addr/wdata appear on mem_addr/mem_data, mem_we = 1 for that cycle only, and rvalid stays 0.

Source files
------------

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing grid memory port A between the game-logic controller (0)
// and a secondary client (1), with bounded read-modify-write locking and read-return steering.
module grid_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_MAX     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  logic                    last;
  logic                    lock_act;
  logic                    lock_own;
  logic [7:0]              lock_cnt;
  logic [7:0]              lock_cnt_inc;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_id;
  logic [ADDR_W-1:0]       addr_hold;
  logic [DATA_W-1:0]       data_hold;

  logic              gnt_any;
  logic              gnt_id;
  logic              gnt_we;
  logic              gnt_lock;
  logic              owner_req;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // While locked, only the owner can be served; otherwise round-robin against last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (lock_act) begin
        if (lock_own) gnt1 = req1;
        else          gnt0 = req0;
      end else if (req0 && req1) begin
        if (last) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    gnt_any   = gnt0 | gnt1;
    gnt_id    = gnt1;
    gnt_we    = gnt1 ? we1    : we0;
    gnt_lock  = gnt1 ? lock1  : lock0;
    gnt_addr  = gnt1 ? addr1  : addr0;
    gnt_data  = gnt1 ? wdata1 : wdata0;
    owner_req = lock_own ? req1 : req0;
    lock_cnt_inc = lock_act ? (lock_cnt + 8'd1) : 8'd1;
  end

  assign mem_we   = gnt_any & gnt_we;
  assign mem_addr = gnt_any ? gnt_addr : addr_hold;
  assign mem_data = gnt_any ? gnt_data : data_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      lock_act  <= 1'b0;
      lock_own  <= 1'b0;
      lock_cnt  <= 8'd0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      if (gnt_any) begin
        last      <= gnt_id;
        addr_hold <= gnt_addr;
        data_hold <= gnt_data;
      end
      if (lock_act && !owner_req) begin
        lock_act <= 1'b0;
        lock_cnt <= 8'd0;
      end else if (gnt_any) begin
        // Expiry drops the lock with last = owner, so the other side wins the next tie
        if (gnt_lock && (lock_cnt_inc < 8'(LOCK_MAX))) begin
          lock_act <= 1'b1;
          lock_own <= gnt_id;
          lock_cnt <= lock_cnt_inc;
        end else begin
          lock_act <= 1'b0;
          lock_cnt <= 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
      pipe_vld[0] <= gnt_any & ~gnt_we;
      pipe_id[0]  <= gnt_any & ~gnt_we & gnt_id;
    end
  end

  assign rvalid0 = pipe_vld[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
  assign rvalid1 = pipe_vld[READ_LATENCY-1] &  pipe_id[READ_LATENCY-1];
  assign rdata   = mem_q;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Directed bench: grant/port checks inline, read returns checked by a scoreboard monitor.
module tb_grid_port_arbiter;

  logic clk;
  logic reset, req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata, mem_addr, mem_data, mem_q;

  logic reset_b, req0_b, req1_b, we0_b, we1_b, lock0_b, lock1_b;
  logic [7:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
  logic gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_we_b;
  logic [7:0] rdata_b, mem_addr_b, mem_data_b, mem_q_b;

  logic [7:0] mem [256];

  typedef struct {
    logic       id;
    logic [7:0] data;
  } resp_t;
  resp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  grid_port_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(1), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  grid_port_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(3), .LOCK_MAX(16)) dut3 (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b), .lock0(lock0_b), .lock1(lock1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b), .rdata(rdata_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_we(mem_we_b), .mem_q(mem_q_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read-first memory, one cycle latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 64);
    mem[8'h2A] = 8'h5C;
    mem[8'h10] = 8'h77;
    mem_q = 8'h00;
    mem_q_b = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] data);
    resp_t r;
    r.id = id;
    r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
  endtask

  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      resp_t r;
      n_checks++;
      if (rvalid0 && rvalid1) begin
        n_errors++;
        $display("FAIL rvalid_both: got rvalid0=1 rvalid1=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rvalid: got rvalid1=%0b rdata=%0h expected no response", rvalid1, rdata);
      end else begin
        r = exp_q.pop_front();
        if (rvalid1 !== r.id || rdata !== r.data) begin
          n_errors++;
          $display("FAIL read_resp: got id=%0b data=%0h expected id=%0b data=%0h",
                   rvalid1, rdata, r.id, r.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; reset_b = 1;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; lock0 = 0; lock1 = 0;
    addr0 = 8'h11; addr1 = 8'h22; wdata0 = 8'h01; wdata1 = 8'h02;
    req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0; lock0_b = 0; lock1_b = 0;
    addr0_b = 8'h07; addr1_b = 8'h08; wdata0_b = 0; wdata1_b = 0;

    // Reset holds everything off even with both requesting writes
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_we", mem_we, 0);
    next_cycle();
    idle();
    reset = 0; reset_b = 0;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_data", mem_data, 8'h00);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    next_cycle();

    // Sole read by requester 0
    req0 = 1; addr0 = 8'h2A;
    @(negedge clk);
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 8'h2A);
    push(0, 8'h5C);
    next_cycle();
    idle();
    @(negedge clk);
    chk("t1_rvalid1", rvalid1, 0);
    chk("t1_addr_hold", mem_addr, 8'h2A);
    next_cycle();

    // Round-robin from a fresh reset
    reset = 1;
    next_cycle();
    reset = 0;
    req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt0", gnt0, (k % 2 == 0));
      chk("rr_gnt1", gnt1, (k % 2 != 0));
      if (k % 2 == 0) push(0, 8'h41);
      else            push(1, 8'h42);
      next_cycle();
    end
    idle();

    // Requester 0 takes one access so requester 1 wins the next tie
    req0 = 1; addr0 = 8'h2A;
    @(negedge clk);
    chk("pre_gnt0", gnt0, 1);
    push(0, 8'h5C);
    next_cycle();

    // Locked read-modify-write by requester 1 while requester 0 waits
    addr0 = 8'h05;
    req1 = 1; we1 = 0; lock1 = 1; addr1 = 8'h10;
    @(negedge clk);
    chk("rmw_rd_gnt1", gnt1, 1);
    chk("rmw_rd_gnt0", gnt0, 0);
    push(1, 8'h77);
    next_cycle();
    we1 = 1; lock1 = 0; wdata1 = 8'h33;
    @(negedge clk);
    chk("rmw_wr_gnt1", gnt1, 1);
    chk("rmw_wr_gnt0", gnt0, 0);
    chk("rmw_wr_mem_we", mem_we, 1);
    chk("rmw_wr_mem_addr", mem_addr, 8'h10);
    chk("rmw_wr_mem_data", mem_data, 8'h33);
    next_cycle();
    req1 = 0; we1 = 0;
    @(negedge clk);
    chk("rmw_after_gnt0", gnt0, 1);
    push(0, 8'h45);
    next_cycle();
    req0 = 0;
    req1 = 1; addr1 = 8'h10;
    @(negedge clk);
    chk("rmw_readback_gnt1", gnt1, 1);
    push(1, 8'h33);
    next_cycle();
    idle();

    // Lock expiry at LOCK_MAX = 4
    req0 = 1; lock0 = 1; addr0 = 8'h03;
    req1 = 1; addr1 = 8'h04;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lockmax_gnt0", gnt0, (k < 4));
      chk("lockmax_gnt1", gnt1, (k == 4));
      if (k < 4) push(0, 8'h43);
      else       push(1, 8'h44);
      next_cycle();
    end
    idle();

    // Both requesters writing: only the winner reaches the port
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'hAA;
    req1 = 1; we1 = 1; addr1 = 8'h21; wdata1 = 8'hBB;
    @(negedge clk);
    chk("wr2_gnt0", gnt0, 1);
    chk("wr2_gnt1", gnt1, 0);
    chk("wr2_mem_we", mem_we, 1);
    chk("wr2_mem_addr", mem_addr, 8'h20);
    chk("wr2_mem_data", mem_data, 8'hAA);
    next_cycle();
    idle();
    @(negedge clk);
    chk("wr2_idle_mem_we", mem_we, 0);
    chk("wr2_idle_addr_hold", mem_addr, 8'h20);
    chk("wr2_idle_data_hold", mem_data, 8'hAA);
    chk("wr2_rvalid0", rvalid0, 0);
    chk("wr2_rvalid1", rvalid1, 0);
    next_cycle();
    req1 = 1; addr1 = 8'h20;
    @(negedge clk);
    push(1, 8'hAA);
    next_cycle();
    addr1 = 8'h21;
    @(negedge clk);
    push(1, 8'h61);
    next_cycle();
    idle();

    // READ_LATENCY = 3 instance: reset drops an in-flight read
    req0_b = 1; addr0_b = 8'h07;
    @(negedge clk);
    chk("rl3_gnt0", gnt0_b, 1);
    next_cycle();
    req0_b = 0;
    reset_b = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rl3_rvalid0", rvalid0_b, 0);
      chk("rl3_rvalid1", rvalid1_b, 0);
      next_cycle();
      reset_b = 0;
    end
    req0_b = 1; req1_b = 1;
    @(negedge clk);
    chk("rl3_tie_gnt0", gnt0_b, 1);
    chk("rl3_tie_gnt1", gnt1_b, 0);
    next_cycle();
    req0_b = 0; req1_b = 0;

    repeat (4) next_cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
